// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_read_arbiter
//  Purpose  : Round-robin arbiter that funnels read bursts from NUM_REQ
//             requesters (0=D-cache, 1=I-cache, 2=stream buffer) onto a single
//             memory read port, owning one outstanding burst at a time.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req_ar*           - per-requester address channel (sliced)
//             req_r*            - per-requester data channel (rdata shared)
//             m_ar*             - memory address channel (m_arid = winner)
//             m_r*              - memory data channel
//  Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [NUM_REQ-1:0]            req_rvalid,
    output logic [NUM_REQ-1:0]            req_rlast,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          m_arvalid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [LEN_WIDTH-1:0]          m_arlen,
    output logic [3:0]                    m_arid,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rlast,
    output logic                          m_rready
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q,   ptr_d;
    logic [PTR_W-1:0]      gnt_q,   gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LEN_WIDTH-1:0]  len_q,   len_d;
    logic [LEN_WIDTH-1:0]  cnt_q,   cnt_d;

    logic                  found;
    logic [PTR_W-1:0]      pick;
    logic [PTR_W:0]        rr_idx;
    logic [LEN_WIDTH-1:0]  len_m1;
    logic                  in_data;
    logic                  last_beat;

    // Round-robin search starting at ptr. rr_idx is one bit wider so the
    // wrap-around subtraction can be done without overflow.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (rr_idx >= (PTR_W+1)'(NUM_REQ)) begin
                rr_idx = rr_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_arvalid[rr_idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = rr_idx[PTR_W-1:0];
            end
        end
    end

    // A registered length of zero behaves as a single-beat burst, so the
    // final beat index is clamped at zero rather than wrapping to all-ones.
    assign len_m1    = (len_q == '0) ? '0 : len_q - LEN_WIDTH'(1);
    assign in_data   = (state_q == S_DATA);
    assign last_beat = in_data && m_rvalid && ((cnt_q == len_m1) || m_rlast);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_ADDR;
                    gnt_d   = pick;
                    ptr_d   = (pick == LAST_IDX) ? '0 : pick + PTR_W'(1);
                    addr_d  = req_araddr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d   = req_arlen[pick*LEN_WIDTH +: LEN_WIDTH];
                end
            end
            S_ADDR: begin
                if (m_arready) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (m_rvalid) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-requester steering: only the granted slot sees handshakes/beats.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        req_rlast   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == PTR_W'(i)) begin
                req_arready[i] = (state_q == S_ADDR) && m_arready;
                req_rvalid[i]  = in_data && m_rvalid;
                req_rlast[i]   = last_beat;
            end
        end
    end

    assign req_rdata = m_rdata;
    assign m_arvalid = (state_q == S_ADDR);
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arid    = 4'(gnt_q);
    assign m_rready  = in_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_read_arbiter
//  Purpose  : Directed scoreboard bench for mem_read_arbiter. Stimulus pushes
//             hand-computed address and beat expectations; a forked monitor
//             pops and compares whenever the DUT presents a handshake/beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_arvalid;
    logic [NR*AW-1:0]  req_araddr;
    logic [NR*LW-1:0]  req_arlen;
    logic [NR-1:0]     req_arready;
    logic [NR-1:0]     req_rvalid;
    logic [NR-1:0]     req_rlast;
    logic [DW-1:0]     req_rdata;
    logic              m_arvalid;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic [3:0]        m_arid;
    logic              m_arready;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              m_rlast;
    logic              m_rready;

    mem_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rlast(req_rlast),
        .req_rdata(req_rdata),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [2:0]  vmask;
        logic        last;
        logic [31:0] data;
    } rb_t;

    ar_t exp_ar[$];
    rb_t exp_r[$];

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.id = id; e.addr = a; e.len = l;
        exp_ar.push_back(e);
    endtask

    // n beats with data base+b; the beat at index last_idx carries rlast.
    task automatic push_beats(input logic [2:0] m, input logic [31:0] base,
                              input int n, input int last_idx);
        rb_t e;
        for (int b = 0; b < n; b++) begin
            e.vmask = m; e.last = (b == last_idx); e.data = base + 32'(b);
            exp_r.push_back(e);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
        req_araddr[i*AW +: AW] = a;
        req_arlen[i*LW +: LW]  = l;
        req_arvalid[i]         = 1'b1;
    endtask

    task automatic monitor();
        ar_t ea;
        rb_t er;
        forever begin
            @(negedge clk);
            if (m_arvalid === 1'b1 && m_arready === 1'b1) begin
                if (exp_ar.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL ar_unexpected: id %0h addr %0h, none expected", m_arid, m_araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_id",   m_arid,   ea.id);
                    chk("ar_addr", m_araddr, ea.addr);
                    chk("ar_len",  m_arlen,  ea.len);
                end
            end
            if ((|req_rvalid) === 1'b1) begin
                if (exp_r.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL r_unexpected: rvalid %b data %0h, none expected", req_rvalid, req_rdata);
                end else begin
                    er = exp_r.pop_front();
                    chk("r_valid", req_rvalid, er.vmask);
                    chk("r_last",  req_rlast,  er.last ? er.vmask : 3'b000);
                    chk("r_data",  req_rdata,  er.data);
                end
            end
        end
    endtask

    // Memory-side responder: waits for m_arvalid, stalls ar_delay cycles
    // (optionally with junk m_rvalid), accepts, then streams nbeats.
    task automatic mem_txn(input int ar_delay, input int nbeats, input logic [31:0] dbase,
                           input bit rlast_final, input bit spur);
        int t;
        logic [3:0] g;
        @(posedge clk); #1;
        t = 0;
        while (m_arvalid !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (m_arvalid !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout: m_arvalid %b after %0d cycles, required 1", m_arvalid, t);
            return;
        end
        repeat (ar_delay) begin
            m_rvalid = spur;
            m_rdata  = 32'hBAD0_BAD0;
            @(posedge clk); #1;
        end
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        g = m_arid;
        @(posedge clk); #1;
        m_arready = 1'b0;
        req_arvalid[g[1:0]] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = dbase + 32'(b);
            m_rlast  = rlast_final && (b == nbeats - 1);
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_arvalid = '0;
        req_araddr  = '0;
        req_arlen   = '0;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_rlast     = 1'b0;
        fork
            monitor();
        join_none

        // Reset with all three requesters already waiting.
        repeat (3) @(posedge clk);
        #1;
        set_req(0, 32'h0000_1000, 8'd1);
        set_req(1, 32'h0000_2000, 8'd1);
        set_req(2, 32'h0000_3000, 8'd1);
        @(negedge clk);
        chk("rst_outputs", {m_arvalid, m_rready, req_arready, req_rvalid, req_rlast}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: expect grants 0,1,2; one-cycle request-to-arvalid latency.
        push_ar(4'd0, 32'h0000_1000, 8'd1); push_beats(3'b001, 32'hA000_0000, 1, 0);
        push_ar(4'd1, 32'h0000_2000, 8'd1); push_beats(3'b010, 32'hA100_0000, 1, 0);
        push_ar(4'd2, 32'h0000_3000, 8'd1); push_beats(3'b100, 32'hA200_0000, 1, 0);
        @(negedge clk);
        chk("lat_before_grant", m_arvalid, 1'b0);
        @(negedge clk);
        chk("lat_after_grant", m_arvalid, 1'b1);
        mem_txn(0, 1, 32'hA000_0000, 1'b1, 1'b0);
        mem_txn(0, 1, 32'hA100_0000, 1'b1, 1'b0);
        mem_txn(0, 1, 32'hA200_0000, 1'b1, 1'b0);

        // ptr must have wrapped to 0: with 0 and 2 waiting, 0 wins first.
        // Junk m_rvalid while waiting in ADDR must be ignored.
        set_req(0, 32'h0000_1100, 8'd1);
        set_req(2, 32'h0000_3300, 8'd2);
        push_ar(4'd0, 32'h0000_1100, 8'd1); push_beats(3'b001, 32'hB000_0000, 1, 0);
        push_ar(4'd2, 32'h0000_3300, 8'd2); push_beats(3'b100, 32'hC000_0000, 2, 1);
        mem_txn(1, 1, 32'hB000_0000, 1'b1, 1'b1);
        mem_txn(0, 2, 32'hC000_0000, 1'b1, 1'b0);

        // Single request from requester 1, two-cycle address stall, 4 beats.
        set_req(1, 32'h0000_0040, 8'd4);
        push_ar(4'd1, 32'h0000_0040, 8'd4); push_beats(3'b010, 32'hD000_0000, 4, 3);
        mem_txn(2, 4, 32'hD000_0000, 1'b1, 1'b0);

        // Early m_rlast on beat 2 of 4 for requester 2 (ptr=2), while
        // requester 1 waits; requester 1 must be granted right after.
        set_req(1, 32'h0000_0050, 8'd3);
        set_req(2, 32'h0000_0080, 8'd4);
        push_ar(4'd2, 32'h0000_0080, 8'd4); push_beats(3'b100, 32'hE000_0000, 2, 1);
        push_ar(4'd1, 32'h0000_0050, 8'd3); push_beats(3'b010, 32'hF000_0000, 3, 2);
        mem_txn(0, 2, 32'hE000_0000, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle_after_last", m_arvalid, 1'b0);
        @(negedge clk);
        chk("no_dead_cycle", m_arvalid, 1'b1);
        mem_txn(0, 3, 32'hF000_0000, 1'b0, 1'b0);

        // Spurious data while idle.
        m_rvalid = 1'b1; m_rdata = 32'h5555_5555; m_rlast = 1'b1;
        @(negedge clk);
        chk("spur_idle_rvalid", req_rvalid, 3'b000);
        chk("spur_idle_rlast",  req_rlast,  3'b000);
        chk("spur_idle_rready", m_rready,   1'b0);
        @(posedge clk); @(posedge clk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Zero length from requester 2: forwarded as 0, first beat is last.
        set_req(2, 32'h0000_0200, 8'd0);
        push_ar(4'd2, 32'h0000_0200, 8'd0); push_beats(3'b100, 32'h0000_0077, 1, 0);
        mem_txn(0, 1, 32'h0000_0077, 1'b0, 1'b0);

        // Reset during beat 2 of a 4-beat burst from requester 0.
        set_req(0, 32'h0000_0300, 8'd4);
        push_ar(4'd0, 32'h0000_0300, 8'd4); push_beats(3'b001, 32'h0000_0090, 2, 99);
        mem_txn(0, 1, 32'h0000_0090, 1'b0, 1'b0);
        m_rvalid = 1'b1; m_rdata = 32'h0000_0091; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_rdata = 32'h0000_0092;
        @(negedge clk);
        chk("rst_mid_outputs", {m_arvalid, m_rready, req_arready, req_rvalid, req_rlast}, 0);
        @(posedge clk); #1;
        m_rdata = 32'h0000_0093; m_rlast = 1'b1;
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Fresh request after the abandoned burst.
        set_req(1, 32'h0000_0400, 8'd2);
        push_ar(4'd1, 32'h0000_0400, 8'd2); push_beats(3'b010, 32'h0000_00A0, 2, 1);
        mem_txn(1, 2, 32'h0000_00A0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ar_queue_drained", exp_ar.size(), 0);
        chk("r_queue_drained",  exp_r.size(),  0);
        chk("final_idle", {m_arvalid, m_rready}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 3, number of read requesters (0=D-cache, 1=I-cache, 2=stream buffer); ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; LEN_WIDTH, default 8, burst-length width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_arvalid  in  NUM_REQ  per-requester read request valid.
- req_araddr  in  NUM_REQ*ADDR_WIDTH  per-requester line address, slice i.
- req_arlen  in  NUM_REQ*LEN_WIDTH  per-requester beat count (beats, not beats-1).
- req_arready  out  NUM_REQ  per-requester address accepted.
- req_rvalid  out  NUM_REQ  per-requester data beat valid.
- req_rlast  out  NUM_REQ  per-requester final beat.
- req_rdata  out  DATA_WIDTH  data beat, shared by all requesters.
- m_arvalid  out  1  memory address valid.
- m_araddr  out  ADDR_WIDTH  memory address.
- m_arlen  out  LEN_WIDTH  memory beat count.
- m_arid  out  4  requester index, zero-extended.
- m_arready  in  1  memory address accepted.
- m_rvalid  in  1  memory data valid.
- m_rdata  in  DATA_WIDTH  memory data.
- m_rlast  in  1  memory final beat.
- m_rready  out  1  data ready.

Function
REQ-003 The block SHALL own exactly one outstanding memory read at a time.
REQ-004 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-005 In IDLE, when any req_arvalid is high, the block SHALL grant one requester by round-robin from priority pointer ptr, register its address, length and index, and enter ADDR next cycle.
REQ-006 Round-robin SHALL search ptr, ptr+1, ..., wrapping modulo NUM_REQ, and pick the first requester with req_arvalid high.
REQ-007 On grant of requester g, ptr SHALL become (g+1) mod NUM_REQ.
REQ-008 Latency SHALL be: req_arvalid seen in IDLE at cycle t gives m_arvalid=1 at cycle t+1.
REQ-009 In ADDR, m_arvalid SHALL be 1 and m_araddr, m_arlen and m_arid SHALL hold the registered values stable until m_arready.
REQ-010 In ADDR, req_arready[g] SHALL equal m_arready; all other bits of req_arready SHALL be 0.
REQ-011 When m_arvalid and m_arready are both high, the FSM SHALL enter DATA and clear the beat counter cnt to 0.
REQ-012 m_rready SHALL be 1 in DATA and 0 otherwise.
REQ-013 In DATA, req_rvalid[g] SHALL equal m_rvalid and req_rdata SHALL equal m_rdata, combinationally with zero added latency.
REQ-014 In DATA, non-granted bits of req_rvalid and req_rlast SHALL be 0.
REQ-015 cnt SHALL increment on each m_rvalid beat in DATA; its width SHALL be LEN_WIDTH.
REQ-016 A beat SHALL be last when m_rvalid && (cnt == len-1 || m_rlast).
REQ-017 A registered length of 0 SHALL be treated as 1.
REQ-018 On the last beat, req_rlast[g] SHALL be 1 and the FSM SHALL return to IDLE.
REQ-019 A new grant SHALL be possible on the cycle after the last beat, with no dead cycle beyond IDLE.
REQ-020 m_rvalid in IDLE or ADDR SHALL be ignored: no req_rvalid, no cnt change.
REQ-021 req_arvalid from any requester SHALL be ignored outside IDLE.
REQ-022 Requesters SHALL hold req_arvalid until req_arready; a deassertion while waiting SHALL cancel the request with no side effect.
REQ-023 If the granted requester drops req_arvalid in ADDR, the issued request SHALL still complete.
REQ-024 Simultaneous requests from all requesters with ptr=0 SHALL be served in order 0,1,2 over successive transactions.

Reset
REQ-025 rst high at a clock edge SHALL force state=IDLE, ptr=0, cnt=0 and clear all registered request fields.
REQ-026 During and after reset, m_arvalid, m_rready, req_arready, req_rvalid and req_rlast SHALL all be 0.
REQ-027 Reset mid-burst SHALL abandon the burst; no req_rvalid SHALL be asserted afterwards for stale beats.

Verification
REQ-028 Single request: req 1 requests addr 0x40 len 4, m_arready after 2 cycles, 4 beats -> m_arid=1, m_araddr=0x40, m_arlen=4; req_rvalid[1] pulses 4 times; req_rlast[1] on beat 4; FSM back to IDLE.
REQ-029 Contention: all three requesters valid at reset exit -> grants in order 0,1,2; ptr after third grant = 0.
REQ-030 Early m_rlast: len 4, m_rlast with beat 2 -> req_rlast on beat 2; next grant possible next cycle.
REQ-031 Spurious data: m_rvalid=1 while in IDLE -> all req_rvalid stay 0; cnt stays 0.
REQ-032 Reset mid-burst: rst during beat 2 of 4 -> outputs 0 the next cycle; remaining m_rvalid beats produce no req_rvalid; a fresh request is then served normally.
REQ-033 Zero length: req 2 len 0 -> m_arlen=0 forwarded; first beat is treated as last.
